// File: rtl/sram_arbiter.sv
// Two-client arbiter for a single async 16-bit SRAM: IDLE -> ACCESS -> ACK per access.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default build is fixed priority (client 0 wins).
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_req,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic              i_we_n0,
    input  logic              i_we_n1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic [1:0]        o_ack,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    inout  wire  [DATA_W-1:0] io_SRAM_DQ,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_LB_N,
    output logic              o_SRAM_UB_N
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              acc_we_n_q, acc_we_n_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              sram_we_n_q, sram_we_n_d;
    logic              sram_oe_n_q, sram_oe_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic              grant_s;

    // Winner selection; id_q doubles as the last-grant record and resets to client 1
    always_comb begin
        grant_s = 1'b0;
`ifdef SRAM_ARB_RR_EN
        if (i_req == 2'b11) begin
            grant_s = ~id_q;
        end else begin
            grant_s = i_req[1];
        end
`else
        if (i_req[0]) begin
            grant_s = 1'b0;
        end else begin
            grant_s = 1'b1;
        end
`endif
    end

    // Next-state and next-output computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        addr_d     = addr_q;
        acc_we_n_d = acc_we_n_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (i_req != 2'b00) begin
                    id_d  = grant_s;
                    cnt_d = CNT_LOAD;
                    if (grant_s) begin
                        addr_d     = i_addr1;
                        acc_we_n_d = i_we_n1;
                        wdata_d    = i_wdata1;
                    end else begin
                        addr_d     = i_addr0;
                        acc_we_n_d = i_we_n0;
                        wdata_d    = i_wdata0;
                    end
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_W'(0)) begin
                    if (acc_we_n_q) begin
                        rdata_d = io_SRAM_DQ;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state they describe
        busy_d      = (state_d != ST_IDLE);
        sram_we_n_d = ~((state_d == ST_ACCESS) && !acc_we_n_d);
        sram_oe_n_d = ~((state_d == ST_ACCESS) && acc_we_n_d);
        dq_oe_d     = (state_d == ST_ACCESS) && !acc_we_n_d;
        if (state_d == ST_ACK) begin
            ack_d = id_d ? 2'b10 : 2'b01;
        end else begin
            ack_d = 2'b00;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            id_q        <= 1'b1;
            addr_q      <= {ADDR_W{1'b0}};
            acc_we_n_q  <= 1'b1;
            wdata_q     <= {DATA_W{1'b0}};
            rdata_q     <= {DATA_W{1'b0}};
            ack_q       <= 2'b00;
            busy_q      <= 1'b0;
            sram_we_n_q <= 1'b1;
            sram_oe_n_q <= 1'b1;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            acc_we_n_q  <= acc_we_n_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            sram_we_n_q <= sram_we_n_d;
            sram_oe_n_q <= sram_oe_n_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    assign o_ack       = ack_q;
    assign o_rdata     = rdata_q;
    assign o_busy      = busy_q;
    assign o_SRAM_ADDR = addr_q;
    assign o_SRAM_WE_N = sram_we_n_q;
    assign o_SRAM_OE_N = sram_oe_n_q;
    assign io_SRAM_DQ  = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
    assign o_SRAM_CE_N = 1'b0;
    assign o_SRAM_LB_N = 1'b0;
    assign o_SRAM_UB_N = 1'b0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: table-driven single accesses with a scoreboard, plus
// contention and mid-access reset sequences; bus rules are checked on every cycle.
module tb_sram_arbiter;

    localparam int AC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [19:0] addr0, addr1;
    logic        we_n0, we_n1;
    logic [15:0] wdata0, wdata1;
    wire  [1:0]  ack;
    wire  [15:0] rdata;
    wire         busy;
    wire  [19:0] sram_addr;
    wire  [15:0] sram_dq;
    wire         we_n, oe_n, ce_n, lb_n, ub_n;

    sram_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(20), .DATA_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .i_addr0(addr0), .i_addr1(addr1),
        .i_we_n0(we_n0), .i_we_n1(we_n1),
        .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_ack(ack), .o_rdata(rdata), .o_busy(busy),
        .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(sram_dq),
        .o_SRAM_WE_N(we_n), .o_SRAM_OE_N(oe_n),
        .o_SRAM_CE_N(ce_n), .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
    );

    always #5 clk = ~clk;

    // SRAM model: bus pulled high when nobody drives, so a floating bus reads 0xFFFF
    pullup (sram_dq);
    logic [15:0] mem [0:1048575];
    logic        preload_done = 1'b0;
    assign sram_dq = (!oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;

    always @(posedge clk) begin
        if (!preload_done) begin
            mem[20'h00010] <= 16'h1234;
            preload_done   <= 1'b1;
        end else if (!we_n) begin
            mem[sram_addr] <= sram_dq;
        end
    end

    typedef struct packed {
        logic [1:0]  ack;
        logic [15:0] rdata;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        int          client;
        logic        we_n;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;
    vec_t vecs [7];

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic        prev_we_n = 1'b1;
    logic [19:0] prev_addr = 20'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, run bus checks and the scoreboard
    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        check("oe_we_exclusive", {31'd0, ~(~oe_n & ~we_n)}, 32'd1);
        check("ack_onehot0", {31'd0, $onehot0(ack)}, 32'd1);
        check("ce_lb_ub_tied", {29'd0, ce_n, lb_n, ub_n}, 32'd0);
        if (!we_n && !prev_we_n) check("addr_stable_we", {12'd0, sram_addr}, {12'd0, prev_addr});
        if (oe_n && we_n) check("dq_released", {16'd0, sram_dq}, 32'h0000FFFF);
        if (!oe_n) check("dq_read_clean", {16'd0, sram_dq}, {16'd0, mem[sram_addr]});
        if (ack != 2'b00) begin
            if (sbq.size() == 0) begin
                check("unexpected_ack", {30'd0, ack}, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("ack_id", {30'd0, ack}, {30'd0, e.ack});
                check("ack_rdata", {16'd0, rdata}, {16'd0, e.rdata});
            end
        end
        prev_we_n = we_n;
        prev_addr = sram_addr;
    endtask

    task automatic do_access(input vec_t v);
        int   n = 0;
        int   oe_cnt = 0;
        int   we_cnt = 0;
        logic got = 1'b0;
        if (v.client == 0) begin
            addr0 = v.addr; we_n0 = v.we_n; wdata0 = v.wdata;
        end else begin
            addr1 = v.addr; we_n1 = v.we_n; wdata1 = v.wdata;
        end
        req[v.client] = 1'b1;
        sbq.push_back({(v.client == 0) ? 2'b01 : 2'b10, v.exp_rdata});
        while (!got && n < 20) begin
            tick();
            n++;
            if (n == 1) check("busy_in_access", {31'd0, busy}, 32'd1);
            if (!oe_n) oe_cnt++;
            if (!we_n) begin
                we_cnt++;
                check("write_dq", {16'd0, sram_dq}, {16'd0, v.wdata});
            end
            if (ack != 2'b00) got = 1'b1;
        end
        req[v.client] = 1'b0;
        check("latency", n, AC + 1);
        check("oe_low_cycles", oe_cnt, v.we_n ? AC : 0);
        check("we_low_cycles", we_cnt, v.we_n ? 0 : AC);
        tick();
        check("busy_back_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks, n, c1_acks, last_cyc;
        logic got;

        vecs[0] = '{0, 1'b1, 20'h00010, 16'h0000, 16'h1234};
        vecs[1] = '{1, 1'b0, 20'hFFFFF, 16'hBEEF, 16'h1234};
        vecs[2] = '{1, 1'b1, 20'hFFFFF, 16'h0000, 16'hBEEF};
        vecs[3] = '{0, 1'b0, 20'h00000, 16'h8001, 16'hBEEF};
        vecs[4] = '{1, 1'b1, 20'h00000, 16'h0000, 16'h8001};
        vecs[5] = '{0, 1'b0, 20'h00010, 16'h7FFF, 16'h8001};
        vecs[6] = '{0, 1'b1, 20'h00010, 16'h0000, 16'h7FFF};

        rst = 1'b1; req = 2'b00;
        addr0 = 20'h0; addr1 = 20'h0; we_n0 = 1'b1; we_n1 = 1'b1;
        wdata0 = 16'h0; wdata1 = 16'h0;
        tick(); tick(); tick();
        check("rst_ack", {30'd0, ack}, 32'd0);
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_addr", {12'd0, sram_addr}, 32'd0);
        check("rst_we_n", {31'd0, we_n}, 32'd1);
        check("rst_oe_n", {31'd0, oe_n}, 32'd1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            do_access(vecs[i]);
        end

        // Reset in the second ACCESS cycle of a write aborts it without an ack
        addr0 = 20'h00020; wdata0 = 16'hA5A5; we_n0 = 1'b0; req = 2'b01;
        tick();
        tick();
        check("abort_write_active", {31'd0, we_n}, 32'd0);
        rst = 1'b1; req = 2'b00;
        tick();
        check("abort_we_n", {31'd0, we_n}, 32'd1);
        check("abort_oe_n", {31'd0, oe_n}, 32'd1);
        check("abort_dq_z", {16'd0, sram_dq}, 32'h0000FFFF);
        check("abort_ack", {30'd0, ack}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("no_ack_after_abort", {30'd0, ack}, 32'd0);
        end

        // Both clients hold req; grants follow the configured arbitration
        addr0 = 20'h00010; we_n0 = 1'b1;
        addr1 = 20'hFFFFF; we_n1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
`ifdef SRAM_ARB_RR_EN
            if (i % 2 == 0) sbq.push_back({2'b01, 16'h7FFF});
            else            sbq.push_back({2'b10, 16'hBEEF});
`else
            sbq.push_back({2'b01, 16'h7FFF});
`endif
        end
        req = 2'b11;
        acks = 0; n = 0; c1_acks = 0; last_cyc = 0;
        while (acks < 20 && n < 200) begin
            tick();
            n++;
            if (ack != 2'b00) begin
                acks++;
                if (ack == 2'b10) c1_acks++;
                if (acks > 1) check("ack_spacing", cyc - last_cyc, AC + 2);
                last_cyc = cyc;
            end
        end
        check("contention_acks", acks, 20);
`ifdef SRAM_ARB_RR_EN
        check("client1_acks", c1_acks, 10);
`else
        check("client1_acks", c1_acks, 0);
`endif
        // Client 0 drops out; client 1 must be served next
        req = 2'b10;
        sbq.push_back({2'b10, 16'hBEEF});
        got = 1'b0; n = 0;
        while (!got && n < 12) begin
            tick();
            n++;
            if (ack != 2'b00) got = 1'b1;
        end
        req = 2'b00;
        check("client1_after_drop", {31'd0, got}, 32'd1);
        tick(); tick();
        check("scoreboard_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
